// File: rtl/ltpi_pkg.sv
// rtl/ltpi_pkg.sv - LTPI frame-type and link-state encodings plus speed/frame helpers
package ltpi_pkg;

  typedef enum logic [2:0] {
    FRM_NONE       = 3'd0,
    FRM_DETECT     = 3'd1,
    FRM_SPEED      = 3'd2,
    FRM_ADVERTISE  = 3'd3,
    FRM_CONFIGURE  = 3'd4,
    FRM_ACCEPT     = 3'd5,
    FRM_DEFAULT_IO = 3'd6,
    FRM_DATA       = 3'd7
  } frame_type_e;

  typedef enum logic [2:0] {
    ST_LINK_DETECT = 3'd0,
    ST_LINK_SPEED  = 3'd1,
    ST_ADVERTISE   = 3'd2,
    ST_CONFIGURE   = 3'd3,
    ST_ACCEPT      = 3'd4,
    ST_OPERATIONAL = 3'd5,
    ST_LINK_LOST   = 3'd6
  } link_state_e;

  // Index of the highest set capability bit; 0 when no common speed exists.
  function automatic logic [3:0] speed_idx(input logic [15:0] cap);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (cap[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Frame type transmitted in each state; training states also expect to receive the same type.
  function automatic frame_type_e tx_type_for(input link_state_e s);
    frame_type_e t;
    case (s)
      ST_LINK_DETECT: t = FRM_DETECT;
      ST_LINK_SPEED:  t = FRM_SPEED;
      ST_ADVERTISE:   t = FRM_ADVERTISE;
      ST_CONFIGURE:   t = FRM_CONFIGURE;
      ST_ACCEPT:      t = FRM_ACCEPT;
      ST_OPERATIONAL: t = FRM_DEFAULT_IO;
      default:        t = FRM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ltpi_sat_counter.sv
// rtl/ltpi_sat_counter.sv - saturating up-counter with synchronous clear
module ltpi_sat_counter #(
  parameter int          WIDTH = 8,
  parameter int unsigned MAX   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear wins over increment; the count holds once it reaches MAX.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count < WIDTH'(MAX))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ltpi_link_fsm.sv
// rtl/ltpi_link_fsm.sv - LTPI link-training state machine; LTPI_LINK_TIMEOUT_EN adds a training timeout
module ltpi_link_fsm
  import ltpi_pkg::*;
#(
  parameter int unsigned CONTROLLER    = 1,
  parameter int unsigned RX_FRM_CNT    = 7,
  parameter int unsigned TX_FRM_CNT    = 255,
  parameter int unsigned ACCEPT_TX_CNT = 1,
  parameter int unsigned LOST_ERR_CNT  = 3,
  parameter int unsigned TIMEOUT_CYC   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_frm_valid,
  input  logic [2:0]  rx_frm_type,
  input  logic        rx_frm_err,
  input  logic [15:0] rx_speed_cap,
  input  logic [15:0] local_speed_cap,
  input  logic        tx_frm_done,
  input  logic        err_clr,
  output logic [2:0]  link_state,
  output logic [2:0]  tx_frm_type,
  output logic [3:0]  speed_sel,
  output logic        speed_change,
  output logic        link_aligned,
  output logic        link_lost_err,
  output logic        link_timeout
);

  localparam int RX_W  = $clog2(RX_FRM_CNT + 1);
  localparam int TX_W  = $clog2(TX_FRM_CNT + 1);
  localparam int ERR_W = $clog2(LOST_ERR_CNT + 1);

  link_state_e  state, state_nxt;
  frame_type_e  tx_type_q;
  logic         trans;
  logic         timeout_hit;
  logic         rx_good, rx_match, train_done;
  logic [15:0]  remote_cap_q;
  logic [RX_W-1:0]  rx_cnt;
  logic [TX_W-1:0]  tx_cnt;
  logic [ERR_W-1:0] err_cnt;

  assign rx_good  = rx_frm_valid && !rx_frm_err;
  assign rx_match = rx_good && (rx_frm_type == tx_type_for(state));
  assign train_done = (rx_cnt >= RX_W'(RX_FRM_CNT)) && (tx_cnt >= TX_W'(TX_FRM_CNT));

  ltpi_sat_counter #(.WIDTH(RX_W), .MAX(RX_FRM_CNT)) u_rx_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (trans || (rx_frm_valid && !rx_match)),
    .inc   (rx_match),
    .count (rx_cnt)
  );

  ltpi_sat_counter #(.WIDTH(TX_W), .MAX(TX_FRM_CNT)) u_tx_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (trans),
    .inc   (tx_frm_done),
    .count (tx_cnt)
  );

  ltpi_sat_counter #(.WIDTH(ERR_W), .MAX(LOST_ERR_CNT)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (trans || rx_good),
    .inc   (state == ST_OPERATIONAL && rx_frm_valid && rx_frm_err),
    .count (err_cnt)
  );

`ifdef LTPI_LINK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] timer_cnt;
  logic             link_timeout_q;

  ltpi_sat_counter #(.WIDTH(TMO_W), .MAX(TIMEOUT_CYC)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (trans),
    .inc   (state != ST_OPERATIONAL),
    .count (timer_cnt)
  );

  assign timeout_hit = (state != ST_OPERATIONAL) && (timer_cnt >= TMO_W'(TIMEOUT_CYC));

  // Sticky timeout flag; a same-cycle clear beats a new timeout.
  always_ff @(posedge clk) begin
    if (reset || err_clr) begin
      link_timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      link_timeout_q <= 1'b1;
    end
  end

  assign link_timeout = link_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit  = 1'b0;
  assign link_timeout = 1'b0;
`endif

  // Next-state decision; a training timeout overrides any other exit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LINK_DETECT: if (train_done) state_nxt = ST_LINK_SPEED;
      ST_LINK_SPEED:  if (train_done) state_nxt = ST_ADVERTISE;
      ST_ADVERTISE: begin
        if (CONTROLLER != 0) begin
          if (train_done) state_nxt = ST_CONFIGURE;
        end else if (rx_good && rx_frm_type == FRM_CONFIGURE) begin
          state_nxt = ST_ACCEPT;
        end
      end
      ST_CONFIGURE:   if (rx_good && rx_frm_type == FRM_ACCEPT) state_nxt = ST_OPERATIONAL;
      ST_ACCEPT:      if (tx_cnt >= TX_W'(ACCEPT_TX_CNT)) state_nxt = ST_OPERATIONAL;
      ST_OPERATIONAL: if (err_cnt == ERR_W'(LOST_ERR_CNT)) state_nxt = ST_LINK_LOST;
      default:        state_nxt = ST_LINK_DETECT;
    endcase
    if (timeout_hit) state_nxt = ST_LINK_DETECT;
  end

  // A timeout in LINK_DETECT re-enters the same state but still restarts all counters.
  assign trans = (state_nxt != state) || timeout_hit;

  // State register with registered frame-type, alignment, speed and link-lost outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_LINK_DETECT;
      tx_type_q     <= FRM_DETECT;
      link_aligned  <= 1'b0;
      speed_sel     <= 4'd0;
      speed_change  <= 1'b0;
      link_lost_err <= 1'b0;
      remote_cap_q  <= 16'd0;
    end else begin
      state        <= state_nxt;
      tx_type_q    <= tx_type_for(state_nxt);
      link_aligned <= (state_nxt == ST_OPERATIONAL);
      speed_change <= 1'b0;
      if (state == ST_LINK_SPEED && rx_good && rx_frm_type == FRM_SPEED) begin
        remote_cap_q <= rx_speed_cap;
      end
      if (state == ST_LINK_SPEED && state_nxt == ST_ADVERTISE) begin
        speed_sel    <= speed_idx(local_speed_cap & remote_cap_q);
        speed_change <= 1'b1;
      end
      if (err_clr) begin
        link_lost_err <= 1'b0;
      end else if (state == ST_OPERATIONAL && state_nxt == ST_LINK_LOST) begin
        link_lost_err <= 1'b1;
      end
    end
  end

  assign link_state  = state;
  assign tx_frm_type = tx_type_q;

endmodule

// File: tb/tb_ltpi_link_fsm.sv
// tb/tb_ltpi_link_fsm.sv - directed bench driving a controller and a target instance side by side
module tb_ltpi_link_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_frm_valid;
  logic [2:0]  rx_frm_type;
  logic        rx_frm_err;
  logic [15:0] rx_speed_cap;
  logic [15:0] local_speed_cap;
  logic        tx_frm_done;
  logic        err_clr;

  logic [2:0] c_state, c_tx, t_state, t_tx;
  logic [3:0] c_speed, t_speed;
  logic       c_chg, c_al, c_lost, c_tmo;
  logic       t_chg, t_al, t_lost, t_tmo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ltpi_link_fsm #(.CONTROLLER(1)) dut_c (
    .clk(clk), .reset(reset), .rx_frm_valid(rx_frm_valid), .rx_frm_type(rx_frm_type),
    .rx_frm_err(rx_frm_err), .rx_speed_cap(rx_speed_cap), .local_speed_cap(local_speed_cap),
    .tx_frm_done(tx_frm_done), .err_clr(err_clr), .link_state(c_state), .tx_frm_type(c_tx),
    .speed_sel(c_speed), .speed_change(c_chg), .link_aligned(c_al), .link_lost_err(c_lost),
    .link_timeout(c_tmo)
  );

  ltpi_link_fsm #(.CONTROLLER(0)) dut_t (
    .clk(clk), .reset(reset), .rx_frm_valid(rx_frm_valid), .rx_frm_type(rx_frm_type),
    .rx_frm_err(rx_frm_err), .rx_speed_cap(rx_speed_cap), .local_speed_cap(local_speed_cap),
    .tx_frm_done(tx_frm_done), .err_clr(err_clr), .link_state(t_state), .tx_frm_type(t_tx),
    .speed_sel(t_speed), .speed_change(t_chg), .link_aligned(t_al), .link_lost_err(t_lost),
    .link_timeout(t_tmo)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [2:0] t, input logic e);
    @(negedge clk);
    rx_frm_valid = 1'b1;
    rx_frm_type  = t;
    rx_frm_err   = e;
    @(negedge clk);
    rx_frm_valid = 1'b0;
    rx_frm_err   = 1'b0;
  endtask

  task automatic send_frames(input logic [2:0] t, input int n);
    for (int i = 0; i < n; i++) send_frame(t, 1'b0);
  endtask

  task automatic tx_pulses(input int n);
    @(negedge clk);
    tx_frm_done = 1'b1;
    repeat (n) @(negedge clk);
    tx_frm_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_frm_valid = 1'b0; rx_frm_type = 3'd0; rx_frm_err = 1'b0;
    rx_speed_cap = 16'h0005; local_speed_cap = 16'h0007; tx_frm_done = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_state_c", c_state, 3'd0);
    check("reset_tx_c", c_tx, 3'd1);
    check("reset_speed_c", c_speed, 4'd0);
    check("reset_flags_c", {c_chg, c_al, c_lost, c_tmo}, 4'b0000);
    check("reset_state_t", t_state, 3'd0);
    check("reset_flags_t", {t_chg, t_al, t_lost, t_tmo}, 4'b0000);

    // LINK_DETECT: tx requirement met, only 6 good frames -> no exit
    tx_pulses(255);
    send_frames(3'd1, 6);
    repeat (3) @(negedge clk);
    check("detect_6_frames_c", c_state, 3'd0);
    check("detect_6_frames_t", t_state, 3'd0);

    // error frame restarts the run: 5 good, 1 err, then 7 good
    send_frame(3'd1, 1'b1);
    send_frames(3'd1, 5);
    check("detect_5_good", c_state, 3'd0);
    send_frame(3'd1, 1'b1);
    check("detect_after_err", c_state, 3'd0);
    send_frames(3'd1, 6);
    check("detect_6_after_err", c_state, 3'd0);
    send_frame(3'd1, 1'b0);
    check("detect_7th_same_cycle", c_state, 3'd0);
    @(negedge clk);
    check("enter_speed_c", c_state, 3'd1);
    check("enter_speed_t", t_state, 3'd1);
    check("speed_tx_type", c_tx, 3'd2);

    // LINK_SPEED: local 0x0007 & remote 0x0005 -> highest common bit 2
    tx_pulses(255);
    send_frames(3'd2, 7);
    check("speed_before_exit", c_state, 3'd1);
    check("speed_change_low_before", c_chg, 1'b0);
    @(negedge clk);
    check("enter_adv_c", c_state, 3'd2);
    check("speed_sel_c", c_speed, 4'd2);
    check("speed_change_pulse_c", c_chg, 1'b1);
    check("speed_sel_t", t_speed, 4'd2);
    check("speed_change_pulse_t", t_chg, 1'b1);
    check("adv_tx_type", c_tx, 3'd3);
    @(negedge clk);
    check("speed_change_one_cycle", {c_chg, t_chg}, 2'b00);

    // ADVERTISE: controller exits on counts, target waits for CONFIGURE
    tx_pulses(255);
    send_frames(3'd3, 7);
    @(negedge clk);
    check("enter_configure_c", c_state, 3'd3);
    check("configure_tx_c", c_tx, 3'd4);
    check("target_stays_adv", t_state, 3'd2);

    send_frame(3'd4, 1'b0);
    check("enter_accept_t", t_state, 3'd4);
    check("accept_tx_t", t_tx, 3'd5);
    check("controller_still_cfg", c_state, 3'd3);

    tx_pulses(1);
    @(negedge clk);
    check("target_operational", t_state, 3'd5);
    check("target_aligned", t_al, 1'b1);
    check("target_tx_default_io", t_tx, 3'd6);
    check("controller_not_aligned", c_al, 1'b0);

    send_frame(3'd5, 1'b0);
    check("controller_operational", c_state, 3'd5);
    check("controller_aligned", c_al, 1'b1);
    check("controller_tx_default_io", c_tx, 3'd6);

    // OPERATIONAL: err, err, good, err, err, err -> LINK_LOST
    send_frame(3'd7, 1'b1);
    send_frame(3'd7, 1'b1);
    send_frame(3'd7, 1'b0);
    send_frame(3'd7, 1'b1);
    send_frame(3'd7, 1'b1);
    check("oper_after_5_frames", c_state, 3'd5);
    send_frame(3'd7, 1'b1);
    check("oper_6th_same_cycle", c_state, 3'd5);
    @(negedge clk);
    check("link_lost_c", c_state, 3'd6);
    check("link_lost_t", t_state, 3'd6);
    check("link_lost_tx_none", c_tx, 3'd0);
    check("link_lost_err_c", c_lost, 1'b1);
    check("link_lost_aligned", c_al, 1'b0);
    @(negedge clk);
    check("back_to_detect_c", c_state, 3'd0);
    check("back_to_detect_tx", c_tx, 3'd1);
    repeat (4) @(negedge clk);
    check("lost_err_sticky_c", c_lost, 1'b1);
    check("lost_err_sticky_t", t_lost, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("lost_err_cleared_c", c_lost, 1'b0);
    check("lost_err_cleared_t", t_lost, 1'b0);
    check("timeout_flag_c", c_tmo, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
